button_event_fsm: RTL and testbench
===================================

BUTTON_EVENT_FSM -- requirements
Module: button_event_fsm

Interface
REQ-001 Parameters SHALL be, one per line:
- LONG_CYCLES, default 50_000_000, held cycles from press to long-press event; legal range 2..2^CNT_W-1.
- REPEAT_CYCLES, default 10_000_000, cycles between auto-repeat events; legal range 1..2^CNT_W-1.
- CNT_W, default 27, width of the internal hold and repeat counters.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  debounced, clk-synchronous button level; 1 = pressed.
- press  output  1  one-cycle pulse on press.
- release  output  1  one-cycle pulse on release.
- long_press  output  1  one-cycle pulse when hold reaches LONG_CYCLES.
- rpt  output  1  one-cycle auto-repeat pulse.
- held  output  1  level, 1 while the button is considered pressed.
- press_cnt  output  8  running count of press events.
REQ-003 All outputs SHALL be driven directly from registers, with no combinational path from in.

Function
REQ-004 The block SHALL implement a 3-state FSM: IDLE, PRESSED, LONG.
REQ-005 In IDLE with in=1 at edge E0, the FSM SHALL go to PRESSED, with press=1, held=1 and hold counter=0 after E0.
REQ-006 In IDLE with in=0, the FSM SHALL remain in IDLE with all pulses at 0.
REQ-007 In PRESSED with in=1, the hold counter SHALL increment by 1 per edge.
REQ-008 At the edge where in=1 and the hold counter equals LONG_CYCLES-1, the FSM SHALL go to LONG, pulse long_press and clear the repeat counter; long_press is therefore visible after edge E0+LONG_CYCLES.
REQ-009 In LONG with in=1, the repeat counter SHALL increment per edge; at the edge where it equals REPEAT_CYCLES-1, rpt SHALL pulse and the counter SHALL reload to 0. rpt pulses SHALL appear after edges E0+LONG_CYCLES+k*REPEAT_CYCLES, k>=1.
REQ-010 In PRESSED or LONG with in=0, the FSM SHALL go to IDLE at that edge, pulse release, set held=0 and clear both counters.
REQ-011 Release SHALL win over any simultaneous threshold: if in=0 at the edge where long_press or rpt would fire, only release SHALL pulse.
REQ-012 Each pulse output SHALL be high for exactly one cycle per event, and pulses SHALL never coincide except as allowed below.
REQ-013 press_cnt SHALL increment by 1 on every press event and wrap from 255 to 0.
REQ-014 A one-cycle press (in=1 at E0, in=0 at E1) SHALL yield press after E0 and release after E1, with no long_press.
REQ-015 Counters SHALL not overflow: the hold counter is only used in PRESSED, and the repeat counter is bounded by the reload in REQ-009.
REQ-016 held SHALL equal (state != IDLE) at all times.

Reset
REQ-017 While rst=1, the block SHALL be in IDLE, all pulses 0, held=0, press_cnt=0 and both counters 0, independent of clk.
REQ-018 Reset asserted mid-hold SHALL abort with no release pulse.
REQ-019 After rst deasserts, if in=1, the first edge SHALL be treated as a new press per REQ-005.

Verification
Bench parameters: LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=8.
REQ-020 Short press: in=1 for 3 cycles -> press at cycle 1, release at cycle 4, no long_press, press_cnt=1.
REQ-021 Long hold: in=1 for 20 cycles -> long_press after E0+8, rpt after E0+12, E0+16 and E0+20 (if still held), release when in falls, held=1 throughout the hold.
REQ-022 Simultaneous event: in drops exactly at edge E0+8 -> release pulses, long_press never pulses.
REQ-023 Wrap: 256 short presses -> press_cnt returns to 0, and the 257th press gives press_cnt=1.
REQ-024 Reset during LONG: assert rst while in=1 -> outputs 0 immediately with no release; deassert rst with in=1 -> press after the next edge, press_cnt=1.
REQ-025 1-cycle glitch: in=1 for a single cycle -> press and release on consecutive cycles, held high for exactly 1 cycle.

Source files
------------

// File: rtl/button_event_fsm.sv
// Button event decoder: turns a debounced button level into press/release,
// long-press and auto-repeat pulses plus a running press count.
module button_event_fsm #(
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int CNT_W         = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   output logic       press,
   output logic       rel,
   output logic       long_press,
   output logic       rpt,
   output logic       held,
   output logic [7:0] press_cnt
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] rpt_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         rpt_cnt    <= '0;
         press      <= 1'b0;
         rel        <= 1'b0;
         long_press <= 1'b0;
         rpt        <= 1'b0;
         held       <= 1'b0;
         press_cnt  <= 8'd0;
      end else begin
         press      <= 1'b0;
         rel        <= 1'b0;
         long_press <= 1'b0;
         rpt        <= 1'b0;
         case (state)
            IDLE: begin
               if (in) begin
                  state     <= PRESSED;
                  press     <= 1'b1;
                  held      <= 1'b1;
                  hold_cnt  <= '0;
                  press_cnt <= press_cnt + 8'd1;
               end
            end
            // release is checked first so it always beats a threshold hit
            PRESSED: begin
               if (!in) begin
                  state    <= IDLE;
                  rel      <= 1'b1;
                  held     <= 1'b0;
                  hold_cnt <= '0;
                  rpt_cnt  <= '0;
               end else if (hold_cnt == LONG_LAST) begin
                  state      <= LONG;
                  long_press <= 1'b1;
                  hold_cnt   <= '0;
                  rpt_cnt    <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            LONG: begin
               if (!in) begin
                  state    <= IDLE;
                  rel      <= 1'b1;
                  held     <= 1'b0;
                  hold_cnt <= '0;
                  rpt_cnt  <= '0;
               end else if (rpt_cnt == RPT_LAST) begin
                  rpt     <= 1'b1;
                  rpt_cnt <= '0;
               end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               held     <= 1'b0;
               hold_cnt <= '0;
               rpt_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed bench for button_event_fsm with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       in;
   logic       press, rel, long_press, rpt, held;
   logic [7:0] press_cnt;

   int n_asserts = 0;
   int n_fail    = 0;

   button_event_fsm #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in(in),
      .press(press), .rel(rel), .long_press(long_press), .rpt(rpt),
      .held(held), .press_cnt(press_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic p, input logic r, input logic lp,
                             input logic rp, input logic h, input logic [7:0] pc);
      chk({tag, ".press"},      {7'd0, press},      {7'd0, p});
      chk({tag, ".release"},    {7'd0, rel},        {7'd0, r});
      chk({tag, ".long_press"}, {7'd0, long_press}, {7'd0, lp});
      chk({tag, ".rpt"},        {7'd0, rpt},        {7'd0, rp});
      chk({tag, ".held"},       {7'd0, held},       {7'd0, h});
      chk({tag, ".press_cnt"},  press_cnt,          pc);
   endtask

   // drive in, take one rising edge, sample 1ns later
   task automatic tick(input logic v);
      in = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pc;
      rst = 1'b1;
      in  = 1'b0;
      #2;
      expect_out("reset_async", 0, 0, 0, 0, 0, 8'd0);
      @(posedge clk); @(posedge clk); #1;
      expect_out("reset_held", 0, 0, 0, 0, 0, 8'd0);
      rst = 1'b0;
      tick(0);
      expect_out("idle", 0, 0, 0, 0, 0, 8'd0);

      // short press: in high for 3 edges
      tick(1); expect_out("short_e0", 1, 0, 0, 0, 1, 8'd1);
      tick(1); expect_out("short_e1", 0, 0, 0, 0, 1, 8'd1);
      tick(1); expect_out("short_e2", 0, 0, 0, 0, 1, 8'd1);
      tick(0); expect_out("short_rel", 0, 1, 0, 0, 0, 8'd1);
      tick(0); expect_out("short_idle", 0, 0, 0, 0, 0, 8'd1);

      // long hold: long_press at E0+8, rpt at E0+12/16/20
      tick(1); expect_out("long_e0", 1, 0, 0, 0, 1, 8'd2);
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         expect_out($sformatf("long_e%0d", i), 0, 0, (i == 8), (i == 12 || i == 16 || i == 20), 1, 8'd2);
      end
      tick(0); expect_out("long_rel", 0, 1, 0, 0, 0, 8'd2);
      tick(0); expect_out("long_idle", 0, 0, 0, 0, 0, 8'd2);

      // release at the long_press edge
      tick(1); expect_out("simlp_e0", 1, 0, 0, 0, 1, 8'd3);
      for (int i = 1; i <= 7; i++) begin
         tick(1);
         expect_out($sformatf("simlp_e%0d", i), 0, 0, 0, 0, 1, 8'd3);
      end
      tick(0); expect_out("simlp_rel", 0, 1, 0, 0, 0, 8'd3);
      tick(0); expect_out("simlp_idle", 0, 0, 0, 0, 0, 8'd3);

      // release at the first rpt edge
      tick(1); expect_out("simrp_e0", 1, 0, 0, 0, 1, 8'd4);
      for (int i = 1; i <= 11; i++) begin
         tick(1);
         expect_out($sformatf("simrp_e%0d", i), 0, 0, (i == 8), 0, 1, 8'd4);
      end
      tick(0); expect_out("simrp_rel", 0, 1, 0, 0, 0, 8'd4);
      tick(0); expect_out("simrp_idle", 0, 0, 0, 0, 0, 8'd4);

      // single-cycle glitch
      tick(1); expect_out("glitch_press", 1, 0, 0, 0, 1, 8'd5);
      tick(0); expect_out("glitch_rel", 0, 1, 0, 0, 0, 8'd5);
      tick(0); expect_out("glitch_idle", 0, 0, 0, 0, 0, 8'd5);

      // wrap: 251 more presses bring the count to 256 -> 0
      pc = 8'd5;
      for (int k = 0; k < 251; k++) begin
         pc = pc + 8'd1;
         tick(1); chk($sformatf("wrap_press%0d", k), {7'd0, press}, 8'd1);
         chk($sformatf("wrap_cnt%0d", k), press_cnt, pc);
         tick(0); chk($sformatf("wrap_rel%0d", k), {7'd0, rel}, 8'd1);
      end
      chk("wrap_zero", press_cnt, 8'd0);
      tick(1); expect_out("wrap_257", 1, 0, 0, 0, 1, 8'd1);
      tick(0); expect_out("wrap_257_rel", 0, 1, 0, 0, 0, 8'd1);

      // reset while in LONG
      tick(1); expect_out("rstl_e0", 1, 0, 0, 0, 1, 8'd2);
      for (int i = 1; i <= 9; i++) begin
         tick(1);
         expect_out($sformatf("rstl_e%0d", i), 0, 0, (i == 8), 0, 1, 8'd2);
      end
      rst = 1'b1;
      #2;
      expect_out("rstl_async", 0, 0, 0, 0, 0, 8'd0);
      @(posedge clk); #1;
      expect_out("rstl_norel", 0, 0, 0, 0, 0, 8'd0);
      rst = 1'b0;
      tick(1); expect_out("rstl_repress", 1, 0, 0, 0, 1, 8'd1);
      tick(1); expect_out("rstl_hold", 0, 0, 0, 0, 1, 8'd1);
      tick(0); expect_out("rstl_rel", 0, 1, 0, 0, 0, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
